spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI Mode-0 master that drives a chip-select, serial clock and MOSI toward the team's `SPI_Slave` and captures MISO. A single transaction carries 1..MAX_BYTES_PER_CS bytes, with CS_n held low throughout. Bytes arrive on a valid/ready handshake; each received byte comes back as a one-cycle valid pulse. The block sits on the SPI-master side of the FPGA, in the w_SPI_Clk domain, and is the initiator counterpart of the slave.

## Interface
- CLKS_PER_HALF_BIT, default 2: w_SPI_Clk cycles per SCLK half-period; legal range 2 or more; SCLK = f(w_SPI_Clk)/(2*CLKS_PER_HALF_BIT).
- MAX_BYTES_PER_CS, default 2: maximum bytes per CS_n-low window; legal range 1..255.
- CS_INACTIVE_CLKS, default 1: minimum CS_n-high cycles between transactions; legal range 1 or more.

Ports:
- w_SPI_Clk  in  1: block clock; all state is rising-edge.
- i_Rst_L  in  1: reset, asynchronous, active-low.
- i_TX_Count  in  8: bytes in this transaction; sampled only with the first i_TX_DV of a transaction; 0 is treated as 1; values above MAX_BYTES_PER_CS are clamped to it.
- i_TX_Byte  in  8: byte to send, MSb first.
- i_TX_DV  in  1: byte valid; accepted only in a cycle where o_TX_Ready=1.
- o_TX_Ready  out  1: master can accept a byte.
- o_RX_DV  out  1: one-cycle pulse; o_RX_Byte is valid.
- o_RX_Byte  out  8: byte captured from MISO.
- o_RX_Count  out  8: index of the byte just received in the current transaction, 0-based; valid with o_RX_DV.
- o_SPI_Clk  out  1: SCLK, idles 0.
- i_SPI_MISO  in  1: slave data.
- o_SPI_MOSI  out  1: master data; 0 whenever CS_n=1.
- o_SPI_CS_n  out  1: active-low chip select.

## Operation
- Mode 0 only (CPOL=0, CPHA=0). MOSI changes on the SCLK falling edge and before the first rising edge. MISO is sampled in the cycle SCLK is driven high.
- States:
  - IDLE: o_TX_Ready=1, CS_n=1.
  - TRANSFER: 16 SCLK half-periods per byte.
  - WAIT_NEXT: CS_n=0, SCLK=0, o_TX_Ready=1; waiting for the next byte.
  - CS_HOLD: CS_n=0 for CLKS_PER_HALF_BIT cycles after the final falling edge.
  - CS_INACTIVE: CS_n=1 for CS_INACTIVE_CLKS cycles.
- IDLE -> TRANSFER: on i_TX_DV. Latch the byte and the clamped count; byte counter = 0.
- TRANSFER end (8th falling edge):
  - Pulse o_RX_DV.
  - If bytes remain, go to WAIT_NEXT.
  - Otherwise go to CS_HOLD, then CS_INACTIVE, then IDLE.
- WAIT_NEXT -> TRANSFER: on i_TX_DV. There is no timeout; CS_n stays low indefinitely.
- o_TX_Ready=0 in TRANSFER, CS_HOLD and CS_INACTIVE. i_TX_DV is ignored in those states.
- RX shifts in LSB-first position, MSb received first: rx <= {rx[6:0], MISO}.
- Reset values:
  - o_SPI_CS_n=1, o_SPI_Clk=0, o_SPI_MOSI=0.
  - o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0.
  - State=IDLE.
- Reset mid-transaction: all outputs return to their reset values immediately (asynchronous). The partial byte is discarded and no o_RX_DV is produced.

## Timing
Let H=CLKS_PER_HALF_BIT and let cycle 0 be the cycle in which i_TX_DV is accepted.
- Cycle 1: CS_n=0 and MOSI=bit7.
- SCLK rises at cycles 1+H, 1+3H, ..., 1+15H. MISO is sampled on each rising edge.
- SCLK falls at cycles 1+2H, ..., 1+16H. MOSI advances to the next bit on falling edges 1..7.
- o_RX_DV=1 exactly in cycle 1+16H; o_RX_Byte and o_RX_Count are valid in that cycle.
- Multi-byte:
  - o_TX_Ready=1 from cycle 1+16H.
  - The next accepted i_TX_DV at cycle k puts MOSI=bit7 at k+1 and the first rise at k+1+H.
  - i_TX_DV asserted in cycle 1+16H gives back-to-back bytes.
- Last byte:
  - CS_n rises at cycle 1+17H.
  - o_TX_Ready rises at cycle 1+17H+CS_INACTIVE_CLKS.
- Throughput constraint: the slave's i_Clk must be at least 4x SCLK. Integration chooses H accordingly.

## Test plan
- Reset:
  - Hold i_Rst_L=0 -> all outputs at reset values.
  - Assert reset mid-byte -> CS_n=1 and SCLK=0 in the same cycle; no o_RX_DV.
- Single byte, H=2:
  - Send 0xA5 with count 1 and MISO looped to MOSI -> MOSI bits 1,0,1,0,0,1,0,1.
  - Rises at cycles 3, 7, ..., 31.
  - o_RX_DV at cycle 33 with o_RX_Byte=0xA5 and o_RX_Count=0.
  - CS_n high at 35; o_TX_Ready high at 36.
- Two bytes back-to-back:
  - Count 2; send 0x3C, then 0xC3 at cycle 33 -> CS_n low continuously.
  - o_RX_DV at 33 (0x3C, count 0) and 66 (0xC3, count 1).
- Stalled second byte:
  - Delay the second i_TX_DV by 50 cycles -> SCLK stays 0, CS_n stays 0, o_TX_Ready=1 throughout.
  - Transfer resumes correctly after the delay.
- Against the slave:
  - Connect to `SPI_Slave` with its i_TX_Byte=0x5A; master sends 0x81 -> master o_RX_Byte=0x5A; slave o_RX_Byte=0x81.
- Boundaries:
  - i_TX_Count=0 -> one byte sent.
  - i_TX_Count=9 with MAX=2 -> two bytes, then CS_n rises.
  - i_TX_DV during TRANSFER -> ignored; MOSI is unchanged.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// Byte handshake and SPI pin bundle for spi_master_ctrl.
// Member names match the legacy port names so existing hookups carry over.
interface spi_master_ctrl_if;
   logic [7:0] i_TX_Count;
   logic [7:0] i_TX_Byte;
   logic       i_TX_DV;
   logic       o_TX_Ready;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic [7:0] o_RX_Count;
   logic       o_SPI_Clk;
   logic       i_SPI_MISO;
   logic       o_SPI_MOSI;
   logic       o_SPI_CS_n;

   modport master (
      input  i_TX_Count, i_TX_Byte, i_TX_DV, i_SPI_MISO,
      output o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count,
             o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
   );

   modport slave (
      output i_TX_Count, i_TX_Byte, i_TX_DV, i_SPI_MISO,
      input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count,
             o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: multi-byte transactions under one CS_n-low window,
// byte-wide valid/ready transmit side and one-cycle receive pulse.
module spi_master_ctrl #(
   parameter int unsigned CLKS_PER_HALF_BIT = 2,
   parameter int unsigned MAX_BYTES_PER_CS  = 2,
   parameter int unsigned CS_INACTIVE_CLKS  = 1
) (
   input logic               w_SPI_Clk,
   input logic               i_Rst_L,
   spi_master_ctrl_if.master bus
);

   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_TRANSFER    = 3'd1;
   localparam logic [2:0] ST_WAIT_NEXT   = 3'd2;
   localparam logic [2:0] ST_CS_HOLD     = 3'd3;
   localparam logic [2:0] ST_CS_INACTIVE = 3'd4;

   localparam logic [15:0] HALF_LAST  = 16'(CLKS_PER_HALF_BIT - 1);
   localparam logic [15:0] INACT_LAST = 16'(CS_INACTIVE_CLKS - 1);
   localparam logic [7:0]  MAX_COUNT  = 8'(MAX_BYTES_PER_CS);

   logic [2:0]  state;
   logic [15:0] half_cnt;
   logic [3:0]  edge_cnt;
   logic [7:0]  tx_sr;
   logic [7:0]  rx_sr;
   logic [7:0]  total;
   logic [7:0]  idx;
   logic [7:0]  count_clamped;
   logic        tx_ready, rx_dv, sclk, mosi, cs_n;
   logic [7:0]  rx_byte, rx_count;

   always_comb begin
      count_clamped = bus.i_TX_Count;
      if (bus.i_TX_Count == '0)
         count_clamped = 8'd1;
      else if (bus.i_TX_Count > MAX_COUNT)
         count_clamped = MAX_COUNT;
   end

   always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state    <= ST_IDLE;
         half_cnt <= '0;
         edge_cnt <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         total    <= 8'd1;
         idx      <= '0;
         tx_ready <= 1'b1;
         rx_dv    <= 1'b0;
         rx_byte  <= '0;
         rx_count <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= 1'b1;
      end else begin
         rx_dv <= 1'b0;
         case (state)
            ST_IDLE, ST_WAIT_NEXT: begin
               if (bus.i_TX_DV) begin
                  // Count is only taken from the first byte of a transaction
                  if (state == ST_IDLE) begin
                     total <= count_clamped;
                     idx   <= '0;
                  end
                  state    <= ST_TRANSFER;
                  tx_ready <= 1'b0;
                  cs_n     <= 1'b0;
                  mosi     <= bus.i_TX_Byte[7];
                  tx_sr    <= {bus.i_TX_Byte[6:0], 1'b0};
                  half_cnt <= '0;
                  edge_cnt <= '0;
               end
            end
            ST_TRANSFER: begin
               if (half_cnt == HALF_LAST) begin
                  half_cnt <= '0;
                  edge_cnt <= edge_cnt + 4'd1;
                  sclk     <= ~sclk;
                  if (!sclk) begin
                     rx_sr <= {rx_sr[6:0], bus.i_SPI_MISO};
                  end else if (edge_cnt == 4'd15) begin
                     rx_dv    <= 1'b1;
                     rx_byte  <= rx_sr;
                     rx_count <= idx;
                     idx      <= idx + 8'd1;
                     if ((idx + 8'd1) < total) begin
                        state    <= ST_WAIT_NEXT;
                        tx_ready <= 1'b1;
                     end else begin
                        state <= ST_CS_HOLD;
                     end
                  end else begin
                     mosi  <= tx_sr[7];
                     tx_sr <= {tx_sr[6:0], 1'b0};
                  end
               end else begin
                  half_cnt <= half_cnt + 16'd1;
               end
            end
            ST_CS_HOLD: begin
               if (half_cnt == HALF_LAST) begin
                  half_cnt <= '0;
                  state    <= ST_CS_INACTIVE;
                  cs_n     <= 1'b1;
                  mosi     <= 1'b0;
               end else begin
                  half_cnt <= half_cnt + 16'd1;
               end
            end
            ST_CS_INACTIVE: begin
               if (half_cnt == INACT_LAST) begin
                  half_cnt <= '0;
                  state    <= ST_IDLE;
                  tx_ready <= 1'b1;
               end else begin
                  half_cnt <= half_cnt + 16'd1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               tx_ready <= 1'b1;
               cs_n     <= 1'b1;
               sclk     <= 1'b0;
               mosi     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_TX_Ready = tx_ready;
   assign bus.o_RX_DV    = rx_dv;
   assign bus.o_RX_Byte  = rx_byte;
   assign bus.o_RX_Count = rx_count;
   assign bus.o_SPI_Clk  = sclk;
   assign bus.o_SPI_MOSI = mosi;
   assign bus.o_SPI_CS_n = cs_n;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: loopback vectors, cycle timing,
// stall/ignore/reset corners and a behavioural mode-0 slave.
module tb_spi_master_ctrl;
   localparam int unsigned H    = 2;
   localparam int unsigned MAXB = 2;
   localparam int unsigned CSI  = 1;

   logic clk   = 1'b0;
   logic rst_l = 1'b0;
   always #5 clk = ~clk;

   spi_master_ctrl_if bus();

   spi_master_ctrl #(
      .CLKS_PER_HALF_BIT(H),
      .MAX_BYTES_PER_CS (MAXB),
      .CS_INACTIVE_CLKS (CSI)
   ) dut (
      .w_SPI_Clk(clk),
      .i_Rst_L  (rst_l),
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural mode-0 slave, selectable in place of MOSI->MISO loopback
   logic       use_slave = 1'b0;
   logic [7:0] s_sr = '0;
   logic [7:0] s_rx = '0;
   always @(negedge bus.o_SPI_CS_n) s_sr = 8'h5A;
   always @(posedge bus.o_SPI_Clk) if (use_slave) s_rx = {s_rx[6:0], bus.o_SPI_MOSI};
   always @(negedge bus.o_SPI_Clk) s_sr = {s_sr[6:0], 1'b0};
   assign bus.i_SPI_MISO = use_slave ? s_sr[7] : bus.o_SPI_MOSI;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] idx;
   } rx_exp_t;
   rx_exp_t sb[$];
   int rx_seen   = 0;
   int cs_rises  = 0;

   always @(negedge clk) begin
      if (rst_l && bus.o_RX_DV === 1'b1) begin
         rx_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rx_dv: got byte %0h count %0h, none expected",
                     bus.o_RX_Byte, bus.o_RX_Count);
         end else begin
            rx_exp_t e;
            e = sb.pop_front();
            check("rx_byte", bus.o_RX_Byte, e.data);
            check("rx_count", bus.o_RX_Count, e.idx);
         end
      end
   end

   always @(posedge bus.o_SPI_CS_n) cs_rises++;

   task automatic wait_ready();
      int unsigned t = 0;
      @(negedge clk);
      while (bus.o_TX_Ready !== 1'b1) begin
         if (t++ > 300) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got not ready expected ready");
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic [7:0] cnt);
      wait_ready();
      bus.i_TX_Byte  = b;
      bus.i_TX_Count = cnt;
      bus.i_TX_DV    = 1'b1;
      @(posedge clk);
      #1 bus.i_TX_DV = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned t = 0;
      @(negedge clk);
      while (!(bus.o_TX_Ready === 1'b1 && bus.o_SPI_CS_n === 1'b1)) begin
         if (t++ > 400) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got cs_n %0b ready %0b expected 1 1",
                     bus.o_SPI_CS_n, bus.o_TX_Ready);
            return;
         end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0]       count;
      logic [1:0][7:0]  bytes;
      int unsigned      gap;
      int unsigned      exp_pulses;
      int unsigned      exp_cs_rises;
   } vec_t;

   vec_t vecs[5];

   logic sclk_r [0:63];
   logic mosi_r [0:63];
   logic csn_r  [0:63];
   logic rdy_r  [0:63];
   logic rxdv_r [0:63];

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.i_TX_Count = '0;
      bus.i_TX_Byte  = '0;
      bus.i_TX_DV    = 1'b0;

      vecs[0] = '{count: 8'd2, bytes: {8'hC3, 8'h3C}, gap: 0,  exp_pulses: 2, exp_cs_rises: 1};
      vecs[1] = '{count: 8'd2, bytes: {8'hAA, 8'h55}, gap: 50, exp_pulses: 2, exp_cs_rises: 1};
      vecs[2] = '{count: 8'd0, bytes: {8'h00, 8'h7E}, gap: 0,  exp_pulses: 1, exp_cs_rises: 1};
      vecs[3] = '{count: 8'd9, bytes: {8'h34, 8'h12}, gap: 0,  exp_pulses: 2, exp_cs_rises: 1};
      vecs[4] = '{count: 8'd1, bytes: {8'h00, 8'h96}, gap: 0,  exp_pulses: 1, exp_cs_rises: 1};

      // Reset values while held
      repeat (3) @(negedge clk);
      check("rst_cs_n",   bus.o_SPI_CS_n, 1);
      check("rst_sclk",   bus.o_SPI_Clk, 0);
      check("rst_mosi",   bus.o_SPI_MOSI, 0);
      check("rst_ready",  bus.o_TX_Ready, 1);
      check("rst_rx_dv",  bus.o_RX_DV, 0);
      check("rst_rx_byte", bus.o_RX_Byte, 0);
      check("rst_rx_count", bus.o_RX_Count, 0);
      rst_l = 1'b1;
      repeat (2) @(negedge clk);

      // Single-byte cycle timing, 0xA5 looped back
      begin
         logic [7:0] a5;
         int unsigned nr;
         a5 = 8'hA5;
         nr = 0;
         cs_rises = 0;
         sb.push_back('{data: 8'hA5, idx: 8'd0});
         send(8'hA5, 8'd1);
         sclk_r[0] = 1'b0;
         for (int k = 1; k <= int'(1 + 17*H + CSI + 2); k++) begin
            @(negedge clk);
            sclk_r[k] = bus.o_SPI_Clk;
            mosi_r[k] = bus.o_SPI_MOSI;
            csn_r[k]  = bus.o_SPI_CS_n;
            rdy_r[k]  = bus.o_TX_Ready;
            rxdv_r[k] = bus.o_RX_DV;
         end
         check("c1_mosi_bit7", mosi_r[1], 1);
         for (int k = 1; k <= int'(1 + 17*H + CSI + 2); k++) begin
            if (sclk_r[k] && !sclk_r[k-1]) begin
               check("rise_cycle", k, 1 + H + 2*H*nr);
               check("rise_mosi", mosi_r[k], a5[7 - nr]);
               nr++;
            end
            check("t_rx_dv", rxdv_r[k], (k == int'(1 + 16*H)));
            check("t_cs_n",  csn_r[k],  (k >= int'(1 + 17*H)));
            check("t_ready", rdy_r[k],  (k >= int'(1 + 17*H + CSI)));
         end
         check("rise_total", nr, 8);
         wait_idle();
         check("t_cs_rises", cs_rises, 1);
         check("t_sb_empty", sb.size(), 0);
      end

      // Table-driven multi-byte vectors
      for (int v = 0; v < 5; v++) begin
         cs_rises = 0;
         rx_seen  = 0;
         for (int unsigned i = 0; i < vecs[v].exp_pulses; i++)
            sb.push_back('{data: vecs[v].bytes[i], idx: 8'(i)});
         send(vecs[v].bytes[0], vecs[v].count);
         for (int unsigned i = 1; i < vecs[v].exp_pulses; i++) begin
            if (vecs[v].gap > 0) begin
               int bad;
               bad = 0;
               wait_ready();
               for (int unsigned g = 0; g < vecs[v].gap; g++) begin
                  if (bus.o_SPI_Clk !== 1'b0 || bus.o_SPI_CS_n !== 1'b0 || bus.o_TX_Ready !== 1'b1)
                     bad++;
                  @(negedge clk);
               end
               check("stall_hold", bad, 0);
            end
            // A different count here must not alter the transaction length
            send(vecs[v].bytes[i], 8'd1);
         end
         wait_idle();
         check("vec_cs_rises", cs_rises, vecs[v].exp_cs_rises);
         check("vec_rx_pulses", rx_seen, vecs[v].exp_pulses);
         check("vec_sb_empty", sb.size(), 0);
      end

      // i_TX_DV during TRANSFER is ignored
      rx_seen = 0;
      sb.push_back('{data: 8'hF0, idx: 8'd0});
      send(8'hF0, 8'd1);
      @(negedge clk);
      bus.i_TX_Byte = 8'h0F;
      bus.i_TX_DV   = 1'b1;
      @(negedge clk);
      check("ign_mosi_a", bus.o_SPI_MOSI, 1);
      @(negedge clk);
      check("ign_mosi_b", bus.o_SPI_MOSI, 1);
      bus.i_TX_DV = 1'b0;
      wait_idle();
      check("ign_rx_pulses", rx_seen, 1);
      check("ign_sb_empty", sb.size(), 0);

      // Against a mode-0 slave model
      use_slave = 1'b1;
      sb.push_back('{data: 8'h5A, idx: 8'd0});
      send(8'h81, 8'd1);
      wait_idle();
      check("slave_rx", s_rx, 8'h81);
      check("slave_sb_empty", sb.size(), 0);
      use_slave = 1'b0;

      // Reset mid-byte
      rx_seen = 0;
      send(8'hFF, 8'd1);
      repeat (10) @(negedge clk);
      #2 rst_l = 1'b0;
      #1;
      check("mid_rst_cs_n",  bus.o_SPI_CS_n, 1);
      check("mid_rst_sclk",  bus.o_SPI_Clk, 0);
      check("mid_rst_mosi",  bus.o_SPI_MOSI, 0);
      check("mid_rst_ready", bus.o_TX_Ready, 1);
      check("mid_rst_rx_dv", bus.o_RX_DV, 0);
      check("mid_rst_rx_byte", bus.o_RX_Byte, 0);
      repeat (3) @(negedge clk);
      rst_l = 1'b1;
      repeat (60) @(negedge clk);
      check("mid_rst_no_rx", rx_seen, 0);
      check("mid_rst_idle_cs", bus.o_SPI_CS_n, 1);

      // Recovery after reset
      sb.push_back('{data: 8'h3A, idx: 8'd0});
      send(8'h3A, 8'd1);
      wait_idle();
      check("recover_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
